// File: rtl/overlap_pkg.sv
// overlap_pkg: shared definitions for the overlap window generator.
//   state_e      - FSM states of overlap_window_gen
//   calc_n_win   - number of complete windows that fit in one input row
//   calc_tail    - trailing pixels of a row that belong to no window
//   params_legal - 1 <= STRIDE <= KERNEL_WIDTH <= INPUT_WIDTH
package overlap_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT   = 2'd1,
    REFILL = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  function automatic bit params_legal(input int iw, input int kw, input int st);
    return (st >= 1) && (st <= kw) && (kw <= iw);
  endfunction

  // The divisor is clamped so an illegal STRIDE reaches the legality error
  // instead of a divide-by-zero during elaboration.
  function automatic int calc_n_win(input int iw, input int kw, input int st);
    int st_safe;
    st_safe = (st < 1) ? 1 : st;
    return (iw - kw) / st_safe + 1;
  endfunction

  function automatic int calc_tail(input int iw, input int kw, input int st);
    return iw - kw - (calc_n_win(iw, kw, st) - 1) * st;
  endfunction

endpackage

// File: rtl/window_shift_buf.sv
// window_shift_buf: KERNEL_WIDTH x BIT_WIDTH register file holding the
// current window.
//   clk_i, rst_i     clock, asynchronous active-low reset (clears all entries)
//   wr_en_i          write wr_data_i into entry wr_idx_i
//   wr_idx_i         write index
//   wr_data_i        write data
//   shift_i          entry[i] <= entry[i+STRIDE]; takes priority over a write
//   rd_idx_i         combinational read index
//   rd_data_o        entry[rd_idx_i], 0 when the index is out of range
module window_shift_buf
  import overlap_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int KERNEL_WIDTH = 5,
  parameter int STRIDE       = 2,
  parameter int IDX_W        = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [BIT_WIDTH-1:0] wr_data_i,
  input  logic                 shift_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  output logic [BIT_WIDTH-1:0] rd_data_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_WIDTH - 1);

  logic [BIT_WIDTH-1:0] mem_q [KERNEL_WIDTH];

  // Entries above KERNEL_WIDTH-STRIDE keep their old value on a shift; they
  // are always rewritten by the refill that follows.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < KERNEL_WIDTH; i++) mem_q[i] <= '0;
    end else if (shift_i) begin
      for (int i = 0; i < KERNEL_WIDTH - STRIDE; i++) mem_q[i] <= mem_q[i+STRIDE];
    end else if (wr_en_i && (wr_idx_i <= LAST_IDX)) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (rd_idx_i <= LAST_IDX) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/overlap_window_gen.sv
// overlap_window_gen: turns a serial row of INPUT_WIDTH pixels into
// overlapping KERNEL_WIDTH-element windows stepping by STRIDE, emitted
// serially. Overlapping pixels are reused from the window buffer, so each
// input pixel is accepted exactly once.
//   clk_i, rst_i   clock, asynchronous active-low reset
//   data_i         input pixel
//   valid_i        data_i valid
//   ready_o        block can accept data_i (decoded from state only)
//   win_o          current window element (registered)
//   valid_o        win_o valid
//   last_o         win_o is the final element of its window
//   win_idx_o      index of the window being emitted, 0..N_WIN-1
//   ready_i        downstream accepts win_o
//   state_o        debug view of the FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a producer holding valid keeps its payload stable until that
// edge, and ready never depends combinationally on the partner's valid.
module overlap_window_gen
  import overlap_pkg::*;
#(
  parameter int BIT_WIDTH    = 8,
  parameter int INPUT_WIDTH  = 9,
  parameter int KERNEL_WIDTH = 5,
  parameter int STRIDE       = 2,
  localparam int N_WIN  = calc_n_win(INPUT_WIDTH, KERNEL_WIDTH, STRIDE),
  localparam int WIDX_W = $clog2(N_WIN) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BIT_WIDTH-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [BIT_WIDTH-1:0] win_o,
  output logic                 valid_o,
  output logic                 last_o,
  output logic [WIDX_W-1:0]    win_idx_o,
  input  logic                 ready_i,
  output state_e               state_o
);

  if (!params_legal(INPUT_WIDTH, KERNEL_WIDTH, STRIDE)) begin : g_bad_params
    $error("overlap_window_gen: need 1 <= STRIDE <= KERNEL_WIDTH <= INPUT_WIDTH");
  end

  localparam int TAIL  = calc_tail(INPUT_WIDTH, KERNEL_WIDTH, STRIDE);
  localparam int IDX_W = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
  localparam int CNT_W = $clog2(KERNEL_WIDTH + 1);

  localparam logic [CNT_W-1:0]  FILL_LAST   = CNT_W'(KERNEL_WIDTH - 1);
  localparam logic [CNT_W-1:0]  REFILL_LAST = CNT_W'(STRIDE - 1);
  localparam logic [CNT_W-1:0]  DRAIN_LAST  = CNT_W'((TAIL > 0) ? TAIL - 1 : 0);
  localparam logic [IDX_W-1:0]  EIDX_LAST   = IDX_W'(KERNEL_WIDTH - 1);
  localparam logic [IDX_W-1:0]  REFILL_BASE = IDX_W'(KERNEL_WIDTH - STRIDE);
  localparam logic [WIDX_W-1:0] WIDX_LAST   = WIDX_W'(N_WIN - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      eidx_q, eidx_d;
  logic [BIT_WIDTH-1:0]  win_q, win_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [WIDX_W-1:0]     widx_q, widx_d;

  logic                  buf_wr_en;
  logic [IDX_W-1:0]      buf_wr_idx;
  logic                  buf_shift;
  logic [IDX_W-1:0]      buf_rd_idx;
  logic [BIT_WIDTH-1:0]  buf_rd_data;
  logic                  in_xfer;
  logic                  out_xfer;
  logic [IDX_W-1:0]      eidx_nxt;
  logic [BIT_WIDTH-1:0]  first_elem;

  assign ready_o  = (state_q != EMIT);
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_q && ready_i;
  assign eidx_nxt = eidx_q + IDX_W'(1);

  // Element 0 of a fresh window; with a single-element kernel it is the
  // pixel being written this very cycle, so bypass the buffer.
  assign first_elem = (KERNEL_WIDTH == 1) ? data_i : buf_rd_data;

  window_shift_buf #(
    .BIT_WIDTH   (BIT_WIDTH),
    .KERNEL_WIDTH(KERNEL_WIDTH),
    .STRIDE      (STRIDE),
    .IDX_W       (IDX_W)
  ) u_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (buf_wr_en),
    .wr_idx_i (buf_wr_idx),
    .wr_data_i(data_i),
    .shift_i  (buf_shift),
    .rd_idx_i (buf_rd_idx),
    .rd_data_o(buf_rd_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    eidx_d     = eidx_q;
    win_d      = win_q;
    valid_d    = valid_q;
    last_d     = last_q;
    widx_d     = widx_q;
    buf_wr_en  = 1'b0;
    buf_wr_idx = '0;
    buf_shift  = 1'b0;
    buf_rd_idx = '0;

    case (state_q)
      FILL: begin
        buf_wr_idx = cnt_q[IDX_W-1:0];
        if (in_xfer) begin
          buf_wr_en = 1'b1;
          if (cnt_q == FILL_LAST) begin
            state_d = EMIT;
            cnt_d   = '0;
            eidx_d  = '0;
            win_d   = first_elem;
            valid_d = 1'b1;
            last_d  = (KERNEL_WIDTH == 1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      REFILL: begin
        buf_wr_idx = REFILL_BASE + cnt_q[IDX_W-1:0];
        if (in_xfer) begin
          buf_wr_en = 1'b1;
          if (cnt_q == REFILL_LAST) begin
            state_d = EMIT;
            cnt_d   = '0;
            eidx_d  = '0;
            win_d   = first_elem;
            valid_d = 1'b1;
            last_d  = (KERNEL_WIDTH == 1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      EMIT: begin
        // Read ahead so the next element is ready to register on a transfer.
        buf_rd_idx = eidx_nxt;
        if (out_xfer) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            cnt_d   = '0;
            if (widx_q < WIDX_LAST) begin
              buf_shift = 1'b1;
              widx_d    = widx_q + WIDX_W'(1);
              state_d   = REFILL;
            end else if (TAIL > 0) begin
              state_d = DRAIN;
            end else begin
              widx_d  = '0;
              state_d = FILL;
            end
          end else begin
            eidx_d = eidx_nxt;
            win_d  = buf_rd_data;
            last_d = (eidx_nxt == EIDX_LAST);
          end
        end
      end

      DRAIN: begin
        if (in_xfer) begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            widx_d  = '0;
            state_d = FILL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      eidx_q  <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eidx_q  <= eidx_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      widx_q  <= widx_d;
    end
  end

  assign win_o     = win_q;
  assign valid_o   = valid_q;
  assign last_o    = last_q;
  assign win_idx_o = widx_q;
  assign state_o   = state_q;

endmodule

// File: doc/overlap_window_gen.md
Name: overlap_window_gen

Overview:
- Producer-side counterpart of the overlap-add accumulator.
- Takes a row of INPUT_WIDTH pixels as a serial valid/ready stream.
- Emits overlapping KERNEL_WIDTH-element windows that step by STRIDE. Elements are sent serially, one per handshake, with a last-of-window flag.
- Overlapping elements are kept in an internal window buffer, so each input pixel is accepted exactly once.

Parameters:
- BIT_WIDTH, 8, element width in bits.
- INPUT_WIDTH, 9, elements per input row.
- KERNEL_WIDTH, 5, elements per output window.
- STRIDE, 2, element step between consecutive windows. Legal range: 1 <= STRIDE <= KERNEL_WIDTH <= INPUT_WIDTH. Illegal values are a compile-time error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- data_i  in  BIT_WIDTH  input pixel.
- valid_i  in  1  data_i valid.
- ready_o  out  1  block can accept data_i.
- win_o  out  BIT_WIDTH  current window element.
- valid_o  out  1  win_o valid.
- last_o  out  1  win_o is element KERNEL_WIDTH-1 of its window.
- win_idx_o  out  clog2(N_WIN)+1  index of the window being emitted, 0..N_WIN-1.
- ready_i  in  1  downstream accepts win_o.

Behaviour:
- Reset clock and polarity: reset rst_i, asynchronous, active-low; clock clk_i.
- Derived constants:
  - N_WIN = (INPUT_WIDTH-KERNEL_WIDTH)/STRIDE + 1
  - TAIL = INPUT_WIDTH - KERNEL_WIDTH - (N_WIN-1)*STRIDE (trailing pixels that fit no window)
- Transfer rules:
  - Input transfer occurs when valid_i && ready_o.
  - Output transfer occurs when valid_o && ready_i.
- Reset values: state=FILL, all counters 0, buffer 0, win_o=0, valid_o=0, last_o=0, win_idx_o=0. ready_o=1 as soon as reset is released.
- ready_o is decoded from the state register only and does not depend on ready_i: 1 in FILL, REFILL and DRAIN; 0 in EMIT.
- FILL:
  - Each input transfer writes buf[cnt] and increments cnt.
  - On the transfer with cnt==KERNEL_WIDTH-1: go to EMIT, load win_o=buf[0] (or data_i if KERNEL_WIDTH==1), valid_o=1, last_o=(KERNEL_WIDTH==1).
  - Latency: the final fill element is accepted at edge t; valid_o is high after edge t.
- EMIT:
  - win_o, last_o and win_idx_o are registered and held stable while valid_o && !ready_i.
  - Each output transfer advances eidx and loads win_o=buf[eidx+1]; last_o=1 exactly when eidx+1==KERNEL_WIDTH-1.
  - On the transfer with last_o=1, valid_o drops to 0 and the next state is chosen:
    - win_idx_o < N_WIN-1: shift buffer down by STRIDE (buf[i] <= buf[i+STRIDE]), increment win_idx_o, go to REFILL.
    - else if TAIL > 0: go to DRAIN.
    - else: go to FILL with win_idx_o=0.
- REFILL:
  - Accept exactly STRIDE elements into buf[KERNEL_WIDTH-STRIDE .. KERNEL_WIDTH-1].
  - On the STRIDE-th transfer, go to EMIT; same 1-cycle latency as FILL.
  - When STRIDE==KERNEL_WIDTH, the whole buffer is replaced (no reuse).
- DRAIN: accept and discard TAIL elements, then go to FILL with win_idx_o=0. valid_o stays 0.
- Stalls:
  - valid_i low holds state and counters unchanged.
  - ready_i low holds all outputs unchanged; no element is dropped or duplicated.
- Reset asserted mid-operation: all state is cleared immediately; the partial row and any partial window are discarded.
- No arithmetic is performed; elements pass through bit-exact.

Decomposition:
- Shared package overlap_pkg holds:
  - state enum (FILL, EMIT, REFILL, DRAIN)
  - functions computing N_WIN and TAIL
  - parameter-legality check
- One natural sub-module: window_shift_buf. It is the KERNEL_WIDTH x BIT_WIDTH register file with indexed write, indexed read, and a STRIDE shift-down.
- The FSM and counters stay in the top level.

Test Plan:
1. Defaults. Input 1..9 with valid_i always high, ready_i always high -> output 1,2,3,4,5 | 3,4,5,6,7 | 5,6,7,8,9. last_o on 5, 7, 9. win_idx_o = 0, 1, 2. ready_o low during each EMIT.
2. INPUT_WIDTH=10, TAIL=1. Input 1..10 then 11..20 -> second row windows start at 11; element 10 never appears; win_idx_o returns to 0.
3. Backpressure. ready_i toggles 1,0,0,1 during EMIT -> win_o and last_o held stable while ready_i=0; output sequence identical to test 1.
4. Input bubbles. valid_i high every third cycle -> same window contents as test 1, no duplicates; valid_o asserts one cycle after the completing input transfer.
5. STRIDE=KERNEL_WIDTH=3, INPUT_WIDTH=9 -> non-overlapping windows 1,2,3 | 4,5,6 | 7,8,9.
6. rst_i pulsed low after the 7th output transfer of a row -> all outputs 0 immediately, ready_o=1 after release; the next input 0xA0.. starts a fresh window 0.
